// File: rtl/imem_pkg.sv
// Shared types and constants for the pipelined instruction memory.
package imem_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Largest supported read latency; sizes the latency counter.
    localparam int MAX_LAT = 4;

    // Word returned for fetches beyond the populated depth.
    localparam logic [31:0] NOP_WORD = 32'h00000000;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x N instruction array: one synchronous write port, one
// combinational read port. Addresses at or beyond DEPTH read as NOP and
// are reported as not writable. Contents rely on the power-up-zero
// configuration of the storage and are never cleared by reset.
module imem_ram
    import imem_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata,
    output logic          waddr_ok
);

    logic [N-1:0] mem [DEPTH];
    logic         raddr_ok;

    // Synchronous write; the caller has already qualified we with waddr_ok.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Range checks only exist when DEPTH leaves part of the address space empty.
    if (DEPTH == (1 << AW)) begin : g_full
        assign raddr_ok = 1'b1;
        assign waddr_ok = 1'b1;
    end else begin : g_part
        localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
        assign raddr_ok = ({1'b0, raddr} < DEPTH_W);
        assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
    end

    assign rdata = raddr_ok ? mem[raddr] : N'(NOP_WORD);

endmodule

// File: rtl/imem_pipelined.sv
// Writable instruction memory with a request/valid fetch handshake and a
// configurable read latency (LAT = 1..4).
//
// Handshake: a fetch is accepted in a cycle where req_i && ready_o; addr_i
// is sampled only then. ready_o is high only in IDLE with no program write
// pending, so a write always beats a simultaneous fetch and the requester
// keeps req_i high until accepted. Exactly LAT cycles after the accept
// cycle, valid_o pulses for one cycle with the word in q_o; q_o holds its
// value otherwise. One fetch completes every LAT+1 cycles.
//
// The word is read from the array in the accept cycle, so later writes
// never change an in-flight result. Writes outside IDLE or beyond DEPTH
// are dropped and prog_err_o pulses the following cycle.
module imem_pipelined
    import imem_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int LAT   = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_i,
    input  logic [AW-1:0] addr_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [N-1:0]  q_o,
    input  logic          prog_we_i,
    input  logic [AW-1:0] prog_addr_i,
    input  logic [N-1:0]  prog_data_i,
    output logic          prog_err_o
);

    localparam int            CW       = $clog2(MAX_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [N-1:0]  rd_data;
    logic [N-1:0]  snap;
    logic          waddr_ok;
    logic          accept;
    logic          wr_en;

    assign accept = req_i && ready_o;
    assign wr_en  = prog_we_i && (state == IDLE) && waddr_ok && !reset;

    imem_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk      (clk),
        .we       (wr_en),
        .waddr    (prog_addr_i),
        .wdata    (prog_data_i),
        .raddr    (addr_i),
        .rdata    (rd_data),
        .waddr_ok (waddr_ok)
    );

    // State register; reset aborts any in-flight fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: IDLE -> (WAIT ->) RESP -> IDLE per accepted fetch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state: ready only when idle and not writing.
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state)
            IDLE:    ready_o = !prog_we_i;
            RESP:    valid_o = 1'b1;
            default: ;
        endcase
    end

    // Latency counter: loaded with LAT-1 on accept, counts down in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if (state == WAIT) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Snapshot of the array word taken in the accept cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            snap <= rd_data;
        end
    end

    // Result register: loaded on entry to RESP, held otherwise. With LAT=1
    // the entry happens on the accept edge, so the array word goes straight in.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_o <= '0;
        end else if (state_nx == RESP && state != RESP) begin
            q_o <= (state == IDLE) ? rd_data : snap;
        end
    end

    // Rejected-write pulse: write attempted while busy or out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_err_o <= 1'b0;
        end else begin
            prog_err_o <= prog_we_i && !((state == IDLE) && waddr_ok);
        end
    end

endmodule

// File: tb/tb_imem_pipelined.sv
// Bench for imem_pipelined: five instances (LAT 1..4 at DEPTH 64, and a
// LAT 1 instance at DEPTH 48) checked every cycle against a timing model
// built from accept-cycle arithmetic, plus literal expectations per scenario.
module tb_imem_pipelined;

    localparam int NI = 5;

    function automatic int lat_of(input int i);
        case (i)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int dep_of(input int i);
        return (i == 4) ? 48 : 64;
    endfunction

    // ---------------- clock / reset / signals ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NI-1:0] req = '0;
    logic [NI-1:0] we = '0;
    logic [5:0]    addr = '0;
    logic [5:0]    paddr = '0;
    logic [31:0]   pdata = '0;
    logic          ready [NI];
    logic          valid [NI];
    logic          perr  [NI];
    logic [31:0]   q     [NI];

    always #5 clk = ~clk;

    imem_pipelined #(.LAT(1)) u0 (
        .clk(clk), .reset(reset), .req_i(req[0]), .addr_i(addr), .ready_o(ready[0]),
        .valid_o(valid[0]), .q_o(q[0]), .prog_we_i(we[0]), .prog_addr_i(paddr),
        .prog_data_i(pdata), .prog_err_o(perr[0]));
    imem_pipelined #(.LAT(2)) u1 (
        .clk(clk), .reset(reset), .req_i(req[1]), .addr_i(addr), .ready_o(ready[1]),
        .valid_o(valid[1]), .q_o(q[1]), .prog_we_i(we[1]), .prog_addr_i(paddr),
        .prog_data_i(pdata), .prog_err_o(perr[1]));
    imem_pipelined #(.LAT(3)) u2 (
        .clk(clk), .reset(reset), .req_i(req[2]), .addr_i(addr), .ready_o(ready[2]),
        .valid_o(valid[2]), .q_o(q[2]), .prog_we_i(we[2]), .prog_addr_i(paddr),
        .prog_data_i(pdata), .prog_err_o(perr[2]));
    imem_pipelined #(.LAT(4)) u3 (
        .clk(clk), .reset(reset), .req_i(req[3]), .addr_i(addr), .ready_o(ready[3]),
        .valid_o(valid[3]), .q_o(q[3]), .prog_we_i(we[3]), .prog_addr_i(paddr),
        .prog_data_i(pdata), .prog_err_o(perr[3]));
    imem_pipelined #(.DEPTH(48), .LAT(1)) u4 (
        .clk(clk), .reset(reset), .req_i(req[4]), .addr_i(addr), .ready_o(ready[4]),
        .valid_o(valid[4]), .q_o(q[4]), .prog_we_i(we[4]), .prog_addr_i(paddr),
        .prog_data_i(pdata), .prog_err_o(perr[4]));

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d actual=%h required=%h time=%0t", name, i, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A fetch accepted in cycle a makes the instance busy in cycles
    // a+1..a+LAT and presents its word (read in cycle a) in cycle a+LAT.
    bit [31:0] m_mem  [NI][64];
    bit        m_pend [NI];
    int        m_acc  [NI];
    bit [31:0] m_data [NI];
    bit [31:0] m_q    [NI];
    bit        m_err  [NI];
    int        cyc = 0;

    function automatic bit m_busy(input int i, input int c);
        return m_pend[i] && (c > m_acc[i]) && (c <= m_acc[i] + lat_of(i));
    endfunction

    always @(posedge clk) begin : model
        bit busy;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_pend[i] = 1'b0;
                m_q[i]    = '0;
                m_err[i]  = 1'b0;
            end else begin
                busy     = m_busy(i, cyc);
                m_err[i] = we[i] && (busy || int'(paddr) >= dep_of(i));
                if (we[i] && !busy && int'(paddr) < dep_of(i))
                    m_mem[i][paddr] = pdata;
                if (!busy && req[i] && !we[i]) begin
                    m_pend[i] = 1'b1;
                    m_acc[i]  = cyc;
                    m_data[i] = (int'(addr) < dep_of(i)) ? m_mem[i][addr] : 32'h0;
                end
                if (m_pend[i] && (cyc + 1 == m_acc[i] + lat_of(i)))
                    m_q[i] = m_data[i];
            end
        end
        cyc++;
    end

    // Every-cycle comparison, sampled mid low phase after stimulus settles.
    always @(negedge clk) begin
        #2;
        if (checking) begin
            for (int i = 0; i < NI; i++) begin
                chk("ready", i, 32'(ready[i]), 32'(!m_busy(i, cyc) && !we[i]));
                chk("valid", i, 32'(valid[i]), 32'(m_pend[i] && cyc == m_acc[i] + lat_of(i)));
                chk("q", i, q[i], m_q[i]);
                chk("prog_err", i, 32'(perr[i]), 32'(m_err[i]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic prog(input logic [NI-1:0] m, input logic [5:0] a, input logic [31:0] d);
        we = m; paddr = a; pdata = d;
        @(negedge clk);
        we = '0;
    endtask

    // Returns the fetched word and the cycles from accept to valid_o.
    task automatic fetch(input int i, input logic [5:0] a, output logic [31:0] d,
                         output int lat);
        int n;
        req[i] = 1'b1; addr = a; n = 0; d = 'x; lat = 0;
        #1;
        while (!ready[i] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!ready[i]) chk("accept_timeout", i, 32'(ready[i]), 32'd1);
        @(negedge clk);
        req[i] = 1'b0;
        n = 1;
        #1;
        while (!valid[i] && n < 10) begin
            @(negedge clk); #1; n++;
        end
        if (valid[i]) begin
            d = q[i]; lat = n;
        end else begin
            chk("valid_timeout", i, 32'(valid[i]), 32'd1);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] load_word(input int a);
        case (a)
            0:  return 32'hf8000001;
            3:  return 32'h8b050083;
            5:  return 32'hcb050083;
            46: return 32'hb400001f;
            default: return 32'h91000000 + 32'(a);
        endcase
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        logic [31:0] d;
        int lat;
        int sweep_mism;

        repeat (2) @(negedge clk);
        checking = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", 0, 32'(ready[0]), 32'd1);
        chk("rst_valid", 3, 32'(valid[3]), 32'd0);
        chk("rst_q", 2, q[2], 32'h0);
        chk("rst_err", 1, 32'(perr[1]), 32'd0);
        @(negedge clk);

        // LAT=1 fetches after loading two words everywhere
        prog(5'b11111, 6'd0, 32'hf8000001);
        prog(5'b11111, 6'd46, 32'hb400001f);
        fetch(0, 6'd0, d, lat);
        chk("lat1_q0", 0, d, 32'hf8000001);
        chk("lat1_lat", 0, 32'(lat), 32'd1);
        fetch(0, 6'd46, d, lat);
        chk("lat1_q46", 0, d, 32'hb400001f);

        // LAT=3 fetch of a written word and of a never-written word
        prog(5'b11111, 6'd3, 32'h8b050083);
        fetch(2, 6'd3, d, lat);
        chk("lat3_q3", 2, d, 32'h8b050083);
        chk("lat3_lat", 2, 32'(lat), 32'd3);
        fetch(2, 6'd10, d, lat);
        chk("lat3_q10", 2, d, 32'h00000000);

        // Write and fetch in the same cycle: the write wins, fetch waits
        req[0] = 1'b1; addr = 6'd5;
        we = 5'b11111; paddr = 6'd5; pdata = 32'hcb050083;
        #1;
        chk("collide_ready", 0, 32'(ready[0]), 32'd0);
        @(negedge clk);
        we = '0;
        fetch(0, 6'd5, d, lat);
        chk("collide_q", 0, d, 32'hcb050083);
        chk("collide_lat", 0, 32'(lat), 32'd1);

        // Write during a LAT=2 fetch is rejected; snapshot is preserved
        req[1] = 1'b1; addr = 6'd0;
        @(negedge clk);
        req[1] = 1'b0;
        we = 5'b00010; paddr = 6'd0; pdata = 32'hdeadbeef;
        @(negedge clk);
        we = '0;
        #1;
        chk("busy_wr_err", 1, 32'(perr[1]), 32'd1);
        chk("busy_wr_valid", 1, 32'(valid[1]), 32'd1);
        chk("busy_wr_q", 1, q[1], 32'hf8000001);
        @(negedge clk);
        fetch(1, 6'd0, d, lat);
        chk("refetch_q", 1, d, 32'hf8000001);
        chk("refetch_lat", 1, 32'(lat), 32'd2);

        // Reset in WAIT on the LAT=4 instance aborts the fetch
        fetch(3, 6'd46, d, lat);
        chk("lat4_q46", 3, d, 32'hb400001f);
        chk("lat4_lat", 3, 32'(lat), 32'd4);
        req[3] = 1'b1; addr = 6'd0;
        @(negedge clk);
        req[3] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("abort_valid", 3, 32'(valid[3]), 32'd0);
            chk("abort_q", 3, q[3], 32'h0);
            chk("abort_ready", 3, 32'(ready[3]), 32'd1);
            @(negedge clk);
        end
        fetch(3, 6'd0, d, lat);
        chk("after_abort_q", 3, d, 32'hf8000001);

        // DEPTH=48 instance: out-of-range write and fetch
        prog(5'b10000, 6'd50, 32'h12345678);
        #1;
        chk("oor_wr_err", 4, 32'(perr[4]), 32'd1);
        @(negedge clk);
        fetch(4, 6'd50, d, lat);
        chk("oor_fetch_q", 4, d, 32'h00000000);
        chk("oor_fetch_lat", 4, 32'(lat), 32'd1);
        prog(5'b10000, 6'd47, 32'hcafef00d);
        fetch(4, 6'd47, d, lat);
        chk("last_word_q", 4, d, 32'hcafef00d);

        // Load 47 words, then sweep the full address range on LAT=1
        for (int a = 0; a < 47; a++) prog(5'b01111, 6'(a), load_word(a));
        sweep_mism = 0;
        for (int a = 0; a < 64; a++) begin
            fetch(0, 6'(a), d, lat);
            if (d !== ((a < 47) ? load_word(a) : 32'h0)) sweep_mism++;
            chk("sweep", 0, d, (a < 47) ? load_word(a) : 32'h0);
        end
        chk("sweep_mismatches", 0, 32'(sweep_mism), 32'd0);

        repeat (2) @(negedge clk);
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
